instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of control_unit and the decode logic. It owns the PC register and issues one request at a time to instruction memory. It then presents the returned instruction, with its PC, to decode under a valid/ready handshake. It honours the decoder's LoadPC (halt on stop), branch/jump redirects and an asynchronous-source flush (trap/restart).

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  instruction memory request (registered)
imem_addr  out  XLEN  request address, equals pc while imem_req=1
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid (earliest 1 cycle after gnt)
imem_rdata  in  32  response instruction
instr  out  32  instruction to decode; 0 when instr_valid=0
instr_pc  out  XLEN  PC of instr
instr_valid  out  1  instr/instr_pc valid
id_ready  in  1  decode consumes instr this cycle
load_pc  in  1  LoadPC from control_unit; 0 = stop
redirect_valid  in  1  branch/jump taken for current instr
redirect_pc  in  XLEN  redirect target
flush  in  1  discard everything, restart at flush_pc
flush_pc  in  XLEN  restart target
halted  out  1  fetch stopped by load_pc=0
stall_cnt  out  32  stall counter (see Optional Feature)

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=FETCH, kill=0. Outputs: imem_req=0 for the reset cycle, instr=0, instr_pc=0, instr_valid=0, halted=0, stall_cnt=0. Reset has priority over every input.
- States: FETCH, WAIT, VALID, HALT.
- FETCH: imem_req=1, imem_addr=pc. If imem_gnt=1, go to WAIT. The request must stay asserted, with addr stable, until gnt.
- WAIT: imem_req=0. On imem_rvalid=1:
  - kill=1: drop the data, clear kill, go to FETCH.
  - kill=0: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, go to VALID.
- VALID: instr/instr_pc held stable while id_ready=0. When id_ready=1:
  - load_pc=1: pc<=redirect_valid ? redirect_pc : pc+4. instr_valid<=0, instr<=0, go to FETCH.
  - load_pc=0: instr_valid<=0, pc unchanged, halted<=1, go to HALT.
  - redirect_valid is ignored unless in VALID with id_ready=1.
- HALT: imem_req=0, instr_valid=0, halted=1. Left only by reset or flush.
- Flush (any state, priority over advance/redirect): pc<=flush_pc, instr_valid<=0, instr<=0, halted<=0, go to FETCH.
  - If flush arrives in WAIT, or in FETCH with imem_gnt=1 the same cycle, the response is still owed. Set kill=1 and go to WAIT; the stale response is discarded.
  - Flush with rvalid in the same WAIT cycle: data dropped, go to FETCH.
- imem_rvalid outside WAIT is ignored. The memory shares rst, so no response survives reset.
- pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC goes to 0). pc[1:0] is passed through unchecked.
- Throughput: at least 3 cycles per instruction (FETCH, WAIT, VALID) with gnt and rvalid at the earliest.

Optional Feature:
IFETCH_STALL_CNT_EN:
- Defined: stall_cnt increments each cycle in WAIT, and each VALID cycle with id_ready=0. It saturates at 32'hFFFF_FFFF, is cleared by rst, and is unaffected by flush.
- Undefined: stall_cnt is tied to 0 and no counter flops are built.

Decomposition:
- Shared defines header (defines.v) holds:
  - fetch state encodings `IF_FETCH/`IF_WAIT/`IF_VALID/`IF_HALT (2-bit)
  - `RESET_PC_DEFAULT
  - `INSTR_BUBBLE = 32'h0 (opcode 0, which control_unit decodes as no-op)
- One sub-module: fetch_next_pc, a combinational priority mux over flush_pc / redirect_pc / pc+4 / pc.

Test Plan:
- Sequential fetch: reset, gnt same cycle, rvalid 1 cycle later with 32'h00500093, id_ready=1 → instr_pc=0, then imem_addr 4, 8, 12 on successive FETCH states, 3 cycles each.
- Backpressure: id_ready=0 for 5 cycles in VALID → instr, instr_pc and instr_valid stable, no imem_req. With the macro defined, stall_cnt=5 plus the WAIT cycles.
- Redirect: in VALID at pc=8, redirect_valid=1, redirect_pc=32'h40, id_ready=1 → next imem_addr=32'h40. A redirect pulse in WAIT → ignored, pc+4 path taken.
- Flush in WAIT: flush_pc=32'h100 → old rdata (32'hDEADBEEF) never appears on instr, next request addr=32'h100.
- Halt: load_pc=0 with id_ready=1 in VALID → halted=1, imem_req stays 0 for 20 cycles. Then flush with flush_pc=32'h200 → halted=0, fetch resumes at 32'h200.
- Wrap and reset: pc=32'hFFFF_FFFC consumed → next addr 0. Asserting rst during WAIT → next cycle instr_valid=0 and imem_req=0, following cycle FETCH at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: fetch state encoding,
// default reset PC and the bubble instruction presented when nothing is valid.
package instr_fetch_unit_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Opcode 0 decodes as a no-op in control_unit.
  localparam logic [INSTR_W-1:0] INSTR_BUBBLE = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_WAIT  = 2'd1,
    IF_VALID = 2'd2,
    IF_HALT  = 2'd3
  } if_state_e;

endpackage

// File: rtl/instr_fetch_unit_next_pc.sv
// Next-PC priority mux for the fetch stage.
// Ports:
//   pc_i             current PC
//   flush_i          restart request (highest priority)
//   flush_pc_i       restart target
//   advance_i        current instruction consumed with LoadPC=1
//   redirect_valid_i branch/jump taken for the consumed instruction
//   redirect_pc_i    branch/jump target
//   next_pc_o        PC for the next cycle (combinational)
module instr_fetch_unit_next_pc #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  input  logic            advance_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] next_pc_o
);

  // Flush beats redirect beats sequential advance beats hold; pc+4 wraps.
  always_comb begin
    next_pc_o = pc_i;
    if (flush_i) begin
      next_pc_o = flush_pc_i;
    end else if (advance_i) begin
      next_pc_o = redirect_valid_i ? redirect_pc_i : pc_i + XLEN'(4);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one request at a time to
// instruction memory and hands the returned word to decode over valid/ready.
// Honours LoadPC (halt), branch/jump redirects and flush (trap/restart).
// Optional build macro: IFETCH_STALL_CNT_EN enables the stall counter;
// without it stall_cnt is tied to zero.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req/imem_addr             request to instruction memory
//   imem_gnt                       request accepted
//   imem_rvalid/imem_rdata         response
//   instr/instr_pc/instr_valid     instruction to decode
//   id_ready                       decode consumes instr
//   load_pc                        0 = stop fetching after this instruction
//   redirect_valid/redirect_pc     branch/jump target for consumed instr
//   flush/flush_pc                 discard everything, restart at flush_pc
//   halted                         fetch stopped by load_pc=0
//   stall_cnt                      WAIT + backpressured VALID cycles
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               id_ready,
  input  logic               load_pc,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               flush,
  input  logic [XLEN-1:0]    flush_pc,
  output logic               halted,
  output logic [31:0]        stall_cnt
);

  if_state_e          state_q;
  logic [XLEN-1:0]    pc_q;
  logic [XLEN-1:0]    pc_d;
  logic               kill_q;
  logic               req_q;
  logic [INSTR_W-1:0] instr_q;
  logic [XLEN-1:0]    instr_pc_q;
  logic               instr_valid_q;
  logic               halted_q;
  logic               advance;
  logic               rsp_owed;

  assign advance = (state_q == IF_VALID) && id_ready && load_pc;

  // A response is still outstanding after this edge: flushing here must
  // wait it out and throw it away.
  assign rsp_owed = ((state_q == IF_WAIT) && !imem_rvalid) ||
                    ((state_q == IF_FETCH) && req_q && imem_gnt);

  instr_fetch_unit_next_pc #(
    .XLEN (XLEN)
  ) u_next_pc (
    .pc_i             (pc_q),
    .flush_i          (flush),
    .flush_pc_i       (flush_pc),
    .advance_i        (advance),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .next_pc_o        (pc_d)
  );

  // Fetch FSM with registered outputs. req_q is 0 for the cycle after
  // reset, so FETCH only honours gnt once the request is actually out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IF_FETCH;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      req_q         <= 1'b0;
      instr_q       <= INSTR_BUBBLE;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (flush) begin
        instr_valid_q <= 1'b0;
        instr_q       <= INSTR_BUBBLE;
        halted_q      <= 1'b0;
        if (rsp_owed) begin
          state_q <= IF_WAIT;
          kill_q  <= 1'b1;
          req_q   <= 1'b0;
        end else begin
          state_q <= IF_FETCH;
          kill_q  <= 1'b0;
          req_q   <= 1'b1;
        end
      end else begin
        case (state_q)
          IF_FETCH: begin
            if (req_q && imem_gnt) begin
              state_q <= IF_WAIT;
              req_q   <= 1'b0;
            end else begin
              req_q <= 1'b1;
            end
          end
          IF_WAIT: begin
            if (imem_rvalid) begin
              if (kill_q) begin
                kill_q  <= 1'b0;
                state_q <= IF_FETCH;
                req_q   <= 1'b1;
              end else begin
                instr_q       <= imem_rdata;
                instr_pc_q    <= pc_q;
                instr_valid_q <= 1'b1;
                state_q       <= IF_VALID;
              end
            end
          end
          IF_VALID: begin
            if (id_ready) begin
              instr_valid_q <= 1'b0;
              instr_q       <= INSTR_BUBBLE;
              if (load_pc) begin
                state_q <= IF_FETCH;
                req_q   <= 1'b1;
              end else begin
                halted_q <= 1'b1;
                state_q  <= IF_HALT;
              end
            end
          end
          IF_HALT: begin
            req_q <= 1'b0;
          end
          default: begin
            state_q <= IF_FETCH;
          end
        endcase
      end
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;

`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating stall counter; flush does not touch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (((state_q == IF_WAIT) || ((state_q == IF_VALID) && !id_ready)) &&
                 (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a transaction-level model of the fetch rules
// plus a behavioural instruction memory, driven by directed scenarios and a
// randomized phase.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] STALE  = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        id_ready;
  logic        load_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        halted;
  logic [31:0] stall_cnt;

  instr_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .id_ready       (id_ready),
    .load_pc        (load_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .halted         (halted),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state (architectural view of the fetch stage).
  logic [31:0] exp_pc;
  logic        exp_valid;
  logic [31:0] exp_instr;
  logic        exp_halted;
  logic [31:0] exp_stall;
  // Behavioural memory: at most one outstanding response.
  logic        pend;
  logic [31:0] pend_addr;
  logic        pend_stale;
  int          pend_dly;

  // Stimulus knobs; redirect and flush are one-cycle pulses.
  bit          k_rand;
  int          k_gnt_pct;
  int          k_dly_min;
  int          k_dly_max;
  logic        k_ready;
  logic        k_load;
  logic        k_redir;
  logic [31:0] k_redir_pc;
  logic        k_flush;
  logic [31:0] k_flush_pc;

  logic [31:0] req_log[$];
  int          req_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset(input int n);
    rst            = 1'b1;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    id_ready       = 1'b0;
    load_pc        = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    flush          = 1'b0;
    flush_pc       = '0;
    repeat (n) @(negedge clk);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    rst        = 1'b0;
    exp_pc     = RST_PC;
    exp_valid  = 1'b0;
    exp_instr  = '0;
    exp_halted = 1'b0;
    exp_stall  = '0;
    pend       = 1'b0;
    pend_stale = 1'b0;
    pend_dly   = 0;
  endtask

  // One clock: check outputs against the model, drive the next inputs,
  // then advance the model across the coming rising edge.
  task automatic tick();
    logic s_valid;
    logic s_pend;
    @(negedge clk);
    cyc++;
    chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
    chk("halted", 32'(halted), 32'(exp_halted));
    chk("imem_req", 32'(imem_req), 32'(!pend && !exp_valid && !exp_halted));
    if (exp_valid) begin
      chk("instr", instr, exp_instr);
      chk("instr_pc", instr_pc, exp_pc);
    end else begin
      chk("bubble", instr, 32'd0);
    end
    if (imem_req) chk("imem_addr", imem_addr, exp_pc);
`ifdef IFETCH_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, exp_stall);
`else
    chk("stall_cnt_tied", stall_cnt, 32'd0);
`endif

    if (k_rand) begin
      k_ready    = ($urandom_range(2) != 0);
      k_load     = ($urandom_range(15) != 0);
      k_redir    = ($urandom_range(3) == 0);
      k_redir_pc = $urandom & 32'hFFFF_FFFC;
      k_flush    = ($urandom_range(24) == 0);
      k_flush_pc = $urandom & 32'hFFFF_FFFC;
    end
    id_ready       = k_ready;
    load_pc        = k_load;
    redirect_valid = k_redir;
    redirect_pc    = k_redir_pc;
    flush          = k_flush;
    flush_pc       = k_flush_pc;
    imem_gnt       = imem_req && (int'($urandom_range(99)) < k_gnt_pct);
    if (pend && pend_dly == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend_stale ? STALE : mem_word(pend_addr);
    end else if (!pend) begin
      imem_rvalid = ($urandom_range(9) == 0);
      imem_rdata  = STALE;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    if (imem_gnt) begin
      req_log.push_back(imem_addr);
      req_cyc.push_back(cyc);
    end

    s_valid = exp_valid;
    s_pend  = pend;
    if (s_pend || (s_valid && !id_ready)) begin
      if (exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
    end
    if (imem_rvalid && s_pend) begin
      pend = 1'b0;
      if (!pend_stale && !flush) begin
        exp_valid = 1'b1;
        exp_instr = mem_word(exp_pc);
      end
    end else if (s_pend && pend_dly > 0) begin
      pend_dly--;
    end
    if (flush) begin
      exp_pc     = flush_pc;
      exp_valid  = 1'b0;
      exp_halted = 1'b0;
      if (pend) pend_stale = 1'b1;
    end else if (s_valid && id_ready) begin
      exp_valid = 1'b0;
      if (load_pc) exp_pc = redirect_valid ? redirect_pc : exp_pc + 32'd4;
      else exp_halted = 1'b1;
    end
    if (imem_gnt) begin
      pend       = 1'b1;
      pend_addr  = imem_addr;
      pend_stale = flush;
      pend_dly   = int'($urandom_range(k_dly_max, k_dly_min));
    end
    k_redir = 1'b0;
    k_flush = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    for (int i = 0; i < bound; i++) begin
      tick();
      if (instr_valid) return;
    end
    chk("wait_valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  initial begin
    k_rand     = 1'b0;
    k_gnt_pct  = 100;
    k_dly_min  = 0;
    k_dly_max  = 0;
    k_ready    = 1'b1;
    k_load     = 1'b1;
    k_redir    = 1'b0;
    k_redir_pc = '0;
    k_flush    = 1'b0;
    k_flush_pc = '0;

    // Sequential fetch at full rate.
    do_reset(2);
    k_ready = 1'b0;
    wait_valid(10);
    chk("first_instr", instr, 32'h0050_0093);
    chk("first_pc", instr_pc, 32'h0);
    k_ready = 1'b1;
    req_log.delete();
    req_cyc.delete();
    repeat (10) tick();
    chk("seq_addr0", req_log[0], 32'd4);
    chk("seq_addr1", req_log[1], 32'd8);
    chk("seq_addr2", req_log[2], 32'd12);
    chk("seq_period", 32'(req_cyc[2] - req_cyc[1]), 32'd3);

    // Backpressure then redirect in VALID, ignored redirect in WAIT.
    do_reset(1);
    k_ready = 1'b0;
    wait_valid(10);
    repeat (5) tick();
    k_ready = 1'b1; tick(); k_ready = 1'b0;
    wait_valid(10);
    k_ready = 1'b1; tick(); k_ready = 1'b0;
    wait_valid(10);
    chk("redir_src_pc", instr_pc, 32'd8);
    k_redir = 1'b1; k_redir_pc = 32'h40; k_ready = 1'b1;
    req_log.delete();
    tick();
    k_ready = 1'b0;
    tick();
    chk("redir_addr", req_log[0], 32'h40);
    k_redir = 1'b1; k_redir_pc = 32'h80;
    tick();
    wait_valid(10);
    req_log.delete();
    k_ready = 1'b1;
    tick();
    tick();
    chk("redir_wait_ignored", req_log[0], 32'h44);

    // Flush while a response is outstanding.
    k_dly_min = 3; k_dly_max = 3;
    k_ready = 1'b0;
    wait_valid(20);
    k_ready = 1'b1; tick(); k_ready = 1'b0;
    tick();
    k_flush = 1'b1; k_flush_pc = 32'h100;
    tick();
    req_log.delete();
    wait_valid(20);
    chk("flush_pc", instr_pc, 32'h100);
    chk("flush_instr", instr, mem_word(32'h100));
    chk("flush_addr", req_log[0], 32'h100);

    // Halt via load_pc=0, then restart by flush.
    k_load = 1'b0; k_ready = 1'b1;
    tick();
    k_load = 1'b1; k_ready = 1'b0;
    req_log.delete();
    repeat (20) tick();
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_no_req", 32'(req_log.size()), 32'd0);
    k_flush = 1'b1; k_flush_pc = 32'h200;
    tick();
    wait_valid(20);
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_pc", instr_pc, 32'h200);

    // PC wrap, then reset in WAIT.
    k_flush = 1'b1; k_flush_pc = 32'hFFFF_FFFC;
    tick();
    wait_valid(20);
    chk("wrap_src_pc", instr_pc, 32'hFFFF_FFFC);
    k_ready = 1'b1;
    req_log.delete();
    tick();
    tick();
    chk("wrap_addr", req_log[0], 32'h0);
    tick();
    do_reset(1);
    tick();
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, RST_PC);

    // Randomized traffic.
    k_rand    = 1'b1;
    k_gnt_pct = 70;
    k_dly_min = 0;
    k_dly_max = 2;
    repeat (3000) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
